// File: rtl/psum_drain_ctrl_pkg.sv
// rtl/psum_drain_ctrl_pkg.sv - shared drain FSM encodings and kernel packing constants
package psum_drain_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Kernels packed into one psum memory word (4 x 8 bit).
  localparam int KN_PER_WORD = 4;

endpackage

// File: rtl/psum_drain_ctrl_fifo.sv
// rtl/psum_drain_ctrl_fifo.sv - first-word-fall-through synchronous FIFO (module sync_fifo_fwft)
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            empty,
  output logic                            full
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW:0]           count_q;
  logic [PW:0]           count_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// rtl/psum_drain_ctrl.sv - walks the psum memory from address 0 and streams every packed word out
module psum_drain_ctrl
  import psum_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_ovld,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_vld,
  output logic                  o_last,
  input  logic                  i_rdy,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [REG_WIDTH-1:0]  dbg_drain_rd_addr,
  output logic [REG_WIDTH-1:0]  dbg_drain_out_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]            state_q, state_d;
  logic [REG_WIDTH-1:0]  total_q, total_d;
  logic [REG_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [REG_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [CW-1:0]         inflight_q, inflight_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW:0]           credits_used;
  logic [REG_WIDTH-1:0]  osize_p1;
  logic [REG_WIDTH-1:0]  groups;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  unused_sig;

  assign osize_p1 = i_conf_outputsize + REG_WIDTH'(1);
  assign groups   = REG_WIDTH'(i_conf_kernelshape[31:16] >> $clog2(KN_PER_WORD));

  // Buffered plus in-flight words never exceed the FIFO, so a returning read always has a slot.
  assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign issue = (state_q == ST_READ) && (credits_used < (CW+1)'(FIFO_DEPTH))
                 && (rd_cnt_q < total_q);

  // Read data with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
  assign push  = mem_ovld && (inflight_q != '0);
  assign pop   = !fifo_empty && i_rdy;

  assign mem_rden          = issue;
  assign mem_radd          = ADDR_WIDTH'(rd_cnt_q);
  assign o_vld             = !fifo_empty;
  assign o_dat             = o_vld ? fifo_dout : '0;
  assign o_last            = o_vld && (out_cnt_q == total_q - REG_WIDTH'(1));
  assign o_busy            = (state_q == ST_SETUP) || (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign o_done            = (state_q == ST_DONE);
  assign dbg_drain_rd_addr = rd_cnt_q;
  assign dbg_drain_out_cnt = out_cnt_q;
  assign unused_sig        = ^{i_conf_kernelshape[15:0], fifo_full};

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = inflight_q;

    if (issue) rd_cnt_d = rd_cnt_q + REG_WIDTH'(1);
    if (pop)   out_cnt_d = out_cnt_q + REG_WIDTH'(1);

    case ({issue, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        total_d   = osize_p1 * groups;
        rd_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = (total_d == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        if (issue && (rd_cnt_q == total_q - REG_WIDTH'(1))) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pop && o_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_start) state_d = ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always @(posedge clk) begin
    if (rst && mem_ovld) begin
      assert (inflight_q != '0) else $error("mem_ovld with no read in flight");
    end
  end

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_odat),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb/tb_psum_drain_ctrl.sv - scoreboard bench for psum_drain_ctrl (two parameterisations)
module tb_psum_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] osize;
  logic [31:0] kshape;
  logic        start     [2];
  logic [31:0] mem_radd  [2];
  logic [31:0] mem_odat  [2];
  logic [31:0] o_dat     [2];
  logic [31:0] dbg_a     [2];
  logic [31:0] dbg_c     [2];
  logic        mem_rden  [2];
  logic        mem_ovld  [2];
  logic        o_vld     [2];
  logic        o_last    [2];
  logic        o_busy    [2];
  logic        o_done    [2];
  logic        ovf_seen  [2];

  logic [32:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  int first_rden, first_vld, rden_cnt, hs_cnt, last_cnt, last_cycle, done_cycle, rden_at13, hold_bad;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MD = (g == 0) ? 1 : 3;
    localparam int FD = (g == 0) ? 4 : 8;
    logic        v_p [MD] = '{default: 1'b0};
    logic [31:0] d_p [MD] = '{default: 32'd0};
    logic [32:0] e;

    psum_drain_ctrl #(.MEM_DELAY(MD), .FIFO_DEPTH(FD)) u_dut (
      .clk (clk), .rst (rst), .i_start (start[g]),
      .i_conf_outputsize (osize), .i_conf_kernelshape (kshape),
      .mem_radd (mem_radd[g]), .mem_rden (mem_rden[g]),
      .mem_odat (mem_odat[g]), .mem_ovld (mem_ovld[g]),
      .o_dat (o_dat[g]), .o_vld (o_vld[g]), .o_last (o_last[g]), .i_rdy (rdy),
      .o_busy (o_busy[g]), .o_done (o_done[g]),
      .dbg_drain_rd_addr (dbg_a[g]), .dbg_drain_out_cnt (dbg_c[g])
    );

    // Memory model: data = address, returned MD cycles after rden; not reset.
    always @(posedge clk) begin
      v_p[0] <= mem_rden[g];
      d_p[0] <= mem_radd[g];
      for (int i = 1; i < MD; i++) begin
        v_p[i] <= v_p[i-1];
        d_p[i] <= d_p[i-1];
      end
    end
    assign mem_ovld[g] = v_p[MD-1];
    assign mem_odat[g] = d_p[MD-1];

    initial ovf_seen[g] = 1'b0;
    always @(negedge clk) begin
      if (rst && u_dut.u_fifo.push && u_dut.u_fifo.full) ovf_seen[g] = 1'b1;
      if (rst && o_vld[g] && rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", o_dat[g], e[31:0]);
          chk("word_last", {31'd0, o_last[g]}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic begin_drain(input int g, input int osz, input int kn);
    int total;
    osize  = osz;
    kshape = kn << 16;
    total  = (osz + 1) * (kn >> 2);
    for (int i = 0; i < total; i++) exp_q.push_back({(i == total - 1), 32'(i)});
    @(posedge clk); #1;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  // mode 0: ready high, 1: ready low cycles 4..13, 2: random ready, 3: stray i_start at cycle 3
  task automatic run(input int g, input int mode, input int maxc, input int stop_c);
    first_rden = 0; first_vld = 0; rden_cnt = 0; hs_cnt = 0; last_cnt = 0;
    last_cycle = 0; done_cycle = 0; rden_at13 = 0; hold_bad = 0;
    for (int c = 1; c <= maxc; c++) begin
      case (mode)
        1:       rdy = !(c >= 4 && c <= 13);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      start[g] = (mode == 3 && c == 3);
      @(negedge clk);
      if (mem_rden[g]) begin
        rden_cnt++;
        if (first_rden == 0) first_rden = c;
      end
      if (o_vld[g] && first_vld == 0) first_vld = c;
      if (o_vld[g] && rdy) begin
        hs_cnt++;
        if (o_last[g]) begin
          last_cnt++;
          last_cycle = c;
        end
      end
      if (mode == 1 && c >= 4 && c <= 13 && !(o_vld[g] && o_dat[g] == 0)) hold_bad++;
      if (c == 13) rden_at13 = rden_cnt;
      if (o_done[g]) begin
        done_cycle = c;
        break;
      end
      if (c == stop_c) break;
      @(posedge clk); #1;
    end
    start[g] = 1'b0;
    if (stop_c == 0) chk("drain_timeout", {31'd0, done_cycle != 0}, 32'd1);
  endtask

  task automatic chk_zero(input int g, input string pre);
    chk({pre, "_rden"}, {31'd0, mem_rden[g]}, 32'd0);
    chk({pre, "_radd"}, mem_radd[g], 32'd0);
    chk({pre, "_vld"},  {31'd0, o_vld[g]}, 32'd0);
    chk({pre, "_last"}, {31'd0, o_last[g]}, 32'd0);
    chk({pre, "_busy"}, {31'd0, o_busy[g]}, 32'd0);
    chk({pre, "_done"}, {31'd0, o_done[g]}, 32'd0);
    chk({pre, "_dat"},  o_dat[g], 32'd0);
    chk({pre, "_dbga"}, dbg_a[g], 32'd0);
    chk({pre, "_dbgc"}, dbg_c[g], 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; osize = 0; kshape = 0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset");
    chk("reset_vld1", {31'd0, o_vld[1]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // basic drain, 8 words
    begin_drain(0, 3, 8);
    run(0, 0, 40, 0);
    chk("basic_first_rden", first_rden, 2);
    chk("basic_first_vld", first_vld, 4);
    chk("basic_rden_cnt", rden_cnt, 8);
    chk("basic_words", hs_cnt, 8);
    chk("basic_last_cnt", last_cnt, 1);
    chk("basic_last_cycle", last_cycle, 11);
    chk("basic_done_cycle", done_cycle, 12);
    chk("basic_dbg_out", dbg_c[0], 8);
    chk("basic_busy_done", {31'd0, o_busy[0]}, 32'd0);
    chk("basic_queue_empty", exp_q.size(), 0);

    // backpressure
    begin_drain(0, 3, 8);
    run(0, 1, 60, 0);
    chk("bp_rden_stall", rden_at13, 4);
    chk("bp_hold", hold_bad, 0);
    chk("bp_words", hs_cnt, 8);
    chk("bp_last_cnt", last_cnt, 1);
    chk("bp_done_cycle", done_cycle, 22);
    chk("bp_queue_empty", exp_q.size(), 0);

    // degenerate: 2 kernels floor to zero groups
    begin_drain(0, 3, 2);
    run(0, 0, 20, 0);
    chk("degen_done_cycle", done_cycle, 2);
    chk("degen_rden", rden_cnt, 0);
    chk("degen_vld", first_vld, 0);

    // stray i_start mid-READ, then restart from DONE
    begin_drain(0, 3, 8);
    run(0, 3, 40, 0);
    chk("restart_words", hs_cnt, 8);
    chk("restart_rden", rden_cnt, 8);
    chk("restart_done_cycle", done_cycle, 12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_hold", {31'd0, o_done[0]}, 32'd1);
    begin_drain(0, 3, 8);
    run(0, 0, 40, 0);
    chk("rerun_first_vld", first_vld, 4);
    chk("rerun_words", hs_cnt, 8);
    chk("rerun_done_cycle", done_cycle, 12);
    chk("rerun_queue_empty", exp_q.size(), 0);
    chk("ovf_dut0", {31'd0, ovf_seen[0]}, 32'd0);

    // random ready, MEM_DELAY=3, FIFO_DEPTH=8, 64 words
    begin_drain(1, 15, 16);
    run(1, 2, 2000, 0);
    chk("rand_words", hs_cnt, 64);
    chk("rand_rden", rden_cnt, 64);
    chk("rand_last_cnt", last_cnt, 1);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("ovf_dut1", {31'd0, ovf_seen[1]}, 32'd0);

    // reset while word 3 is presented and reads are in flight
    begin_drain(0, 3, 8);
    run(0, 0, 40, 6);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rden_active", {31'd0, mem_rden[0]}, 32'd1);
    chk("midrst_word3", o_dat[0], 3);
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero(0, "midrst");
    chk("midrst_late_ovld", {31'd0, mem_ovld[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dropped", {31'd0, o_vld[0]}, 32'd0);
    exp_q.delete();
    begin_drain(0, 3, 8);
    run(0, 0, 40, 0);
    chk("post_rst_words", hs_cnt, 8);
    chk("post_rst_done_cycle", done_cycle, 12);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
